// File: rtl/lcd_panel_model.sv
// Panel-side responder for a KS0066-style parallel LCD bus: 2x16 DDRAM image, address
// counter, display flags, busy timing and sticky protocol-error reporting.
module lcd_panel_model #(
  parameter int unsigned InsBusyTime   = 4,
  parameter int unsigned ClearBusyTime = 16
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       E,
  input  logic       RS,
  input  logic       RW,
  input  logic [7:0] DB,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       err
);

  localparam int unsigned MaxBusy = (ClearBusyTime > InsBusyTime) ? ClearBusyTime : InsBusyTime;
  localparam int unsigned CntW    = $clog2(MaxBusy + 1);
  localparam logic [7:0]  Blank   = 8'h20;

  logic [7:0]      mem_q [32];
  logic            e_q, rs_q, rw_q;
  logic [7:0]      db_q;
  logic [CntW-1:0] busy_cnt_q, busy_cnt_d;
  logic            id_q, id_d;
  logic [6:0]      ac_q, ac_d;
  logic            disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic            err_q, err_d;
  logic [7:0]      db_hold_q, db_hold_d;
  logic [7:0]      rd_char_q;
  logic            strobe, wr_en, clr_all;
  logic [7:0]      cur_cell, live_rd;

  // Only columns 0x0-0xF of each line are backed; the rest of each line is address space only.
  function automatic logic cell_valid(input logic [6:0] a);
    return a[5:4] == 2'b00;
  endfunction

  function automatic logic [4:0] cell_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  assign strobe   = e_q & ~E;
  assign busy     = busy_cnt_q != '0;
  assign cur_cell = cell_valid(ac_q) ? mem_q[cell_idx(ac_q)] : Blank;
  assign live_rd  = RS ? cur_cell : {busy, ac_q};
  assign db_oe    = E & RW;
  assign db_out   = db_oe ? live_rd : db_hold_q;
  assign db_hold_d = db_oe ? live_rd : db_hold_q;

  assign ac        = ac_q;
  assign rd_char   = rd_char_q;
  assign disp_on   = disp_q;
  assign cursor_on = cur_q;
  assign blink_on  = blink_q;
  assign err       = err_q;

  always_comb begin
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    clr_all    = 1'b0;
    busy_cnt_d = busy ? busy_cnt_q - CntW'(1) : busy_cnt_q;
    if (strobe) begin
      // Busy-flag reads are always legal; anything else while busy is dropped.
      if (busy && !(!rs_q && rw_q)) begin
        err_d = 1'b1;
      end else begin
        unique case ({rs_q, rw_q})
          2'b00: begin
            if (db_q[7]) begin
              ac_d       = db_q[6:0];
              err_d      = err_q | (db_q[5:0] >= 6'h28);
              busy_cnt_d = CntW'(InsBusyTime);
            end else if (db_q[6]) begin
              busy_cnt_d = CntW'(InsBusyTime);
            end else if (db_q[5]) begin
              err_d      = err_q | ~db_q[4];
              busy_cnt_d = CntW'(InsBusyTime);
            end else if (db_q[4]) begin
              if (!db_q[3]) ac_d = ac_step(ac_q, db_q[2]);
              busy_cnt_d = CntW'(InsBusyTime);
            end else if (db_q[3]) begin
              disp_d     = db_q[2];
              cur_d      = db_q[1];
              blink_d    = db_q[0];
              busy_cnt_d = CntW'(InsBusyTime);
            end else if (db_q[2]) begin
              id_d       = db_q[1];
              busy_cnt_d = CntW'(InsBusyTime);
            end else if (db_q[1]) begin
              ac_d       = 7'h00;
              busy_cnt_d = CntW'(ClearBusyTime);
            end else if (db_q[0]) begin
              clr_all    = 1'b1;
              ac_d       = 7'h00;
              id_d       = 1'b1;
              busy_cnt_d = CntW'(ClearBusyTime);
            end
          end
          2'b10: begin
            wr_en      = cell_valid(ac_q);
            ac_d       = ac_step(ac_q, id_q);
            busy_cnt_d = CntW'(InsBusyTime);
          end
          2'b01: ;
          2'b11: begin
            ac_d       = ac_step(ac_q, id_q);
            busy_cnt_d = CntW'(InsBusyTime);
          end
        endcase
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= Blank;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      db_q       <= 8'h00;
      busy_cnt_q <= '0;
      id_q       <= 1'b1;
      ac_q       <= 7'h00;
      disp_q     <= 1'b0;
      cur_q      <= 1'b0;
      blink_q    <= 1'b0;
      err_q      <= 1'b0;
      db_hold_q  <= 8'h00;
      rd_char_q  <= Blank;
    end else begin
      e_q <= E;
      if (E) begin
        rs_q <= RS;
        rw_q <= RW;
        db_q <= DB;
      end
      if (clr_all) begin
        for (int i = 0; i < 32; i++) mem_q[i] <= Blank;
      end else if (wr_en) begin
        mem_q[cell_idx(ac_q)] <= db_q;
      end
      busy_cnt_q <= busy_cnt_d;
      id_q       <= id_d;
      ac_q       <= ac_d;
      disp_q     <= disp_d;
      cur_q      <= cur_d;
      blink_q    <= blink_d;
      err_q      <= err_d;
      db_hold_q  <= db_hold_d;
      rd_char_q  <= mem_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_lcd_panel_model.sv
// Scoreboard bench for lcd_panel_model: bus strobes driven from tasks, a local image model
// predicts DDRAM contents, and expectations are queued then popped against DUT outputs.
module tb_lcd_panel_model;

  logic       mclk = 1'b0;
  logic       rst  = 1'b1;
  logic       E = 1'b0, RS = 1'b0, RW = 1'b0;
  logic [7:0] DB = 8'h00;
  logic [7:0] db_out;
  logic       db_oe;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       busy, disp_on, cursor_on, blink_on, err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [32];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         blen;
  logic [7:0] rd_val;
  logic       rd_oe;

  lcd_panel_model #(
    .InsBusyTime  (4),
    .ClearBusyTime(16)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .E        (E),
    .RS       (RS),
    .RW       (RW),
    .DB       (DB),
    .db_out   (db_out),
    .db_oe    (db_oe),
    .rd_addr  (rd_addr),
    .rd_char  (rd_char),
    .ac       (ac),
    .busy     (busy),
    .disp_on  (disp_on),
    .cursor_on(cursor_on),
    .blink_on (blink_on),
    .err      (err)
  );

  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  // Queue an expectation for a signal that is already settled, then pop it at the next negedge.
  task automatic expect_state(input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    @(negedge mclk);
    case (tag)
      "ac":     sb_pop(32'(ac));
      "busy":   sb_pop(32'(busy));
      "err":    sb_pop(32'(err));
      "disp":   sb_pop(32'(disp_on));
      "cursor": sb_pop(32'(cursor_on));
      "blink":  sb_pop(32'(blink_on));
      "db_oe":  sb_pop(32'(db_oe));
      "db_out": sb_pop(32'(db_out));
      default:  sb_pop(32'hdead);
    endcase
  endtask

  task automatic do_reset();
    @(posedge mclk); #1;
    rst = 1'b1; E = 1'b0;
    @(posedge mclk); #1;
    @(posedge mclk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
  endtask

  // One-cycle E pulse; returns on the edge that executes it.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] db);
    @(posedge mclk); #1;
    E = 1'b1; RS = rs; RW = rw; DB = db;
    @(posedge mclk); #1;
    E = 1'b0;
    @(posedge mclk);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    busy_len(n);
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] val, output logic oe);
    @(posedge mclk); #1;
    E = 1'b1; RS = rs; RW = 1'b1;
    @(negedge mclk);
    val = db_out;
    oe  = db_oe;
    @(posedge mclk); #1;
    E = 1'b0;
  endtask

  // Pipelined sweep: an expectation is queued as each address is driven and popped when
  // rd_char presents it one cycle later.
  task automatic sweep();
    for (int i = 0; i <= 32; i++) begin
      @(posedge mclk); #1;
      if (i < 32) begin
        rd_addr = 5'(i);
        sb_push($sformatf("cell%0d", i), 32'(model[i]));
      end
      @(negedge mclk);
      if (i > 0) sb_pop(32'(rd_char));
    end
  endtask

  initial begin
    do_reset();

    // Reset state
    sweep();
    expect_state("ac", 0);
    expect_state("busy", 0);
    expect_state("err", 0);
    expect_state("disp", 0);
    expect_state("db_oe", 0);
    expect_state("db_out", 0);

    // Data writes and busy window
    strobe(1'b0, 1'b0, 8'h80);
    busy_len(blen); check("busy_len_setaddr", 32'(blen), 32'd4);
    strobe(1'b1, 1'b0, 8'h48);
    expect_state("ac", 1);
    busy_len(blen); check("busy_len_wr0", 32'(blen), 32'd3);
    strobe(1'b1, 1'b0, 8'h49);
    busy_len(blen); check("busy_len_wr1", 32'(blen), 32'd4);
    model[0] = 8'h48; model[1] = 8'h49;
    expect_state("ac", 2);
    sweep();

    // Data read drives DDRAM[ac], holds after E falls, then steps ac
    strobe(1'b0, 1'b0, 8'h80);
    wait_idle();
    bus_read(1'b1, rd_val, rd_oe);
    check("rd_data", 32'(rd_val), 32'h48);
    check("rd_data_oe", 32'(rd_oe), 32'd1);
    expect_state("db_oe", 0);
    expect_state("db_out", 8'h48);
    expect_state("ac", 1);
    wait_idle();

    // Increment wrap 0x27 -> 0x40, then decrement wrap 0x40 -> 0x27 and 0x00 -> 0x67
    strobe(1'b0, 1'b0, 8'hA7); wait_idle();
    expect_state("ac", 7'h27);
    strobe(1'b1, 1'b0, 8'h41); wait_idle();
    expect_state("ac", 7'h40);
    strobe(1'b0, 1'b0, 8'h04); wait_idle();
    strobe(1'b1, 1'b0, 8'h42); wait_idle();
    model[16] = 8'h42;
    expect_state("ac", 7'h27);
    strobe(1'b0, 1'b0, 8'h80); wait_idle();
    strobe(1'b1, 1'b0, 8'h33); wait_idle();
    model[0] = 8'h33;
    expect_state("ac", 7'h67);
    sweep();

    // Display control
    strobe(1'b0, 1'b0, 8'h0F); wait_idle();
    expect_state("disp", 1);
    expect_state("cursor", 1);
    expect_state("blink", 1);
    strobe(1'b0, 1'b0, 8'h0C); wait_idle();
    expect_state("cursor", 0);
    expect_state("err", 0);

    // Clear: long busy window, blank image, ac=0, increment restored
    strobe(1'b0, 1'b0, 8'h01);
    busy_len(blen); check("busy_len_clear", 32'(blen), 32'd16);
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    expect_state("ac", 0);
    sweep();
    strobe(1'b0, 1'b0, 8'h01);
    repeat (3) @(negedge mclk);
    bus_read(1'b0, rd_val, rd_oe);
    check("busy_read", 32'(rd_val), 32'h80);
    check("busy_read_oe", 32'(rd_oe), 32'd1);
    wait_idle();
    expect_state("err", 0);
    strobe(1'b1, 1'b0, 8'h50); wait_idle();
    model[0] = 8'h50;
    expect_state("ac", 1);

    // Strobe while busy is dropped and latches err
    strobe(1'b1, 1'b0, 8'h61);
    strobe(1'b1, 1'b0, 8'h55);
    wait_idle();
    model[1] = 8'h61;
    expect_state("ac", 2);
    expect_state("err", 1);
    sweep();
    strobe(1'b0, 1'b0, 8'h02); wait_idle();
    expect_state("err", 1);

    // Reset mid-busy
    strobe(1'b0, 1'b0, 8'h01);
    expect_state("busy", 1);
    do_reset();
    expect_state("busy", 0);
    expect_state("err", 0);
    expect_state("disp", 0);

    // Unbacked-but-illegal address and 4-bit function set raise err
    strobe(1'b0, 1'b0, 8'hA8); wait_idle();
    expect_state("ac", 7'h28);
    expect_state("err", 1);
    do_reset();
    strobe(1'b0, 1'b0, 8'h38); wait_idle();
    expect_state("err", 0);
    strobe(1'b0, 1'b0, 8'h28); wait_idle();
    expect_state("err", 1);
    do_reset();

    // E held high never executes; the eventual fall does
    @(posedge mclk); #1;
    E = 1'b1; RS = 1'b1; RW = 1'b0; DB = 8'h77;
    repeat (20) @(posedge mclk);
    expect_state("busy", 0);
    expect_state("ac", 0);
    @(posedge mclk); #1;
    E = 1'b0;
    @(posedge mclk);
    expect_state("ac", 1);
    wait_idle();
    model[0] = 8'h77;

    // Strobe coinciding with reset is discarded
    @(posedge mclk); #1;
    E = 1'b1; RS = 1'b1; RW = 1'b0; DB = 8'h11;
    @(posedge mclk); #1;
    E = 1'b0; rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    expect_state("ac", 0);
    expect_state("busy", 0);
    sweep();

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
